// File: rtl/operand_fetch_pkg.sv
// Shared widths and operand types for the operand fetch front end.
package operand_fetch_pkg;

   localparam int XLEN     = 32;
   localparam int IDX_W    = 5;
   localparam int REG_ZERO = 0;

   typedef struct packed {
      logic [XLEN-1:0]  value;
      logic [IDX_W-1:0] idx;
   } operand_t;

endpackage

// File: rtl/opfetch_operand.sv
// One operand lane: pending-stage forward capture, x0 forcing, and the
// output-stage load / write-back snoop select.
module opfetch_operand #(
   parameter int XLEN  = operand_fetch_pkg::XLEN,
   parameter int IDX_W = operand_fetch_pkg::IDX_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             p_load,
   input  logic             p_hold,
   input  logic             adv,
   input  logic             o_hold,
   input  logic [IDX_W-1:0] in_rs,
   input  logic [XLEN-1:0]  rf_data,
   input  logic [IDX_W-1:0] wb_idx,
   input  logic [XLEN-1:0]  wb_data,
   input  logic             wb_enable,
   output logic [IDX_W-1:0] rd_idx,
   output logic [XLEN-1:0]  out_val
);
   import operand_fetch_pkg::*;

   logic [IDX_W-1:0] p_rs;
   logic [IDX_W-1:0] o_idx;
   logic             p_fwd;
   logic [XLEN-1:0]  p_fwd_data;
   logic [XLEN-1:0]  p_val;
   logic             hit_rd;
   logic             hit_p;
   logic             hit_o;

   function automatic logic wb_hit(input logic             en,
                                   input logic [IDX_W-1:0] widx,
                                   input logic [IDX_W-1:0] r);
      return en && (widx == r) && (r != IDX_W'(REG_ZERO));
   endfunction

   // A held entry re-reads its own index; otherwise the new request is read.
   assign rd_idx = p_hold ? p_rs : in_rs;

   assign hit_rd = wb_hit(wb_enable, wb_idx, rd_idx);
   assign hit_p  = wb_hit(wb_enable, wb_idx, p_rs);
   assign hit_o  = wb_hit(wb_enable, wb_idx, o_idx);

   always_comb begin
      p_val = rf_data;
      if (p_rs == IDX_W'(REG_ZERO))
         p_val = '0;
      else if (p_fwd)
         p_val = p_fwd_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         p_rs       <= '0;
         p_fwd      <= 1'b0;
         p_fwd_data <= '0;
         o_idx      <= '0;
         out_val    <= '0;
      end else begin
         if (p_load)
            p_rs <= in_rs;
         // The file read issued at this edge cannot see a same-edge write.
         if (p_load || p_hold) begin
            p_fwd      <= hit_rd;
            p_fwd_data <= wb_data;
         end
         if (adv) begin
            o_idx   <= p_rs;
            out_val <= hit_p ? wb_data : p_val;
         end else if (o_hold && hit_o) begin
            out_val <= wb_data;
         end
      end
   end

endmodule

// File: rtl/operand_fetch.sv
// Decode-to-execute operand fetch: two-stage pipeline with write-back snooping.
// Optional stall_cycles counter is enabled by defining OPFETCH_STALL_CNT_EN.
module operand_fetch #(
   parameter int XLEN  = operand_fetch_pkg::XLEN,
   parameter int IDX_W = operand_fetch_pkg::IDX_W,
   parameter int TAG_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IDX_W-1:0] in_rs1,
   input  logic [IDX_W-1:0] in_rs2,
   input  logic [TAG_W-1:0] in_tag,
   output logic [IDX_W-1:0] rf_read_idx_1,
   output logic [IDX_W-1:0] rf_read_idx_2,
   input  logic [XLEN-1:0]  rf_read_data_1,
   input  logic [XLEN-1:0]  rf_read_data_2,
   input  logic [IDX_W-1:0] wb_idx,
   input  logic [XLEN-1:0]  wb_data,
   input  logic             wb_enable,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_rs1_val,
   output logic [XLEN-1:0]  out_rs2_val,
   output logic [TAG_W-1:0] out_tag
`ifdef OPFETCH_STALL_CNT_EN
   ,
   output logic [31:0]      stall_cycles
`endif
);
   import operand_fetch_pkg::*;

   logic             p_valid;
   logic [TAG_W-1:0] p_tag;
   logic             adv;
   logic             accept;
   logic             p_hold;
   logic             o_hold;

   assign adv      = p_valid && (!out_valid || out_ready);
   assign in_ready = !p_valid || adv;
   assign accept   = in_valid && in_ready;
   assign p_hold   = p_valid && !adv;
   assign o_hold   = out_valid && !out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         p_valid   <= 1'b0;
         p_tag     <= '0;
         out_valid <= 1'b0;
         out_tag   <= '0;
      end else begin
         if (accept) begin
            p_valid <= 1'b1;
            p_tag   <= in_tag;
         end else if (adv) begin
            p_valid <= 1'b0;
         end
         if (adv) begin
            out_valid <= 1'b1;
            out_tag   <= p_tag;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   opfetch_operand #(.XLEN(XLEN), .IDX_W(IDX_W)) u_op1 (
      .clk       (clk),
      .reset     (reset),
      .p_load    (accept),
      .p_hold    (p_hold),
      .adv       (adv),
      .o_hold    (o_hold),
      .in_rs     (in_rs1),
      .rf_data   (rf_read_data_1),
      .wb_idx    (wb_idx),
      .wb_data   (wb_data),
      .wb_enable (wb_enable),
      .rd_idx    (rf_read_idx_1),
      .out_val   (out_rs1_val)
   );

   opfetch_operand #(.XLEN(XLEN), .IDX_W(IDX_W)) u_op2 (
      .clk       (clk),
      .reset     (reset),
      .p_load    (accept),
      .p_hold    (p_hold),
      .adv       (adv),
      .o_hold    (o_hold),
      .in_rs     (in_rs2),
      .rf_data   (rf_read_data_2),
      .wb_idx    (wb_idx),
      .wb_data   (wb_data),
      .wb_enable (wb_enable),
      .rd_idx    (rf_read_idx_2),
      .out_val   (out_rs2_val)
   );

`ifdef OPFETCH_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (reset)
         stall_cycles <= '0;
      else if (o_hold && (stall_cycles != 32'hFFFF_FFFF))
         stall_cycles <= stall_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch with a behavioural register file.
module tb_operand_fetch;
   localparam int XLEN  = 32;
   localparam int IDX_W = 5;
   localparam int TAG_W = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [IDX_W-1:0] in_rs1, in_rs2;
   logic [TAG_W-1:0] in_tag;
   logic [IDX_W-1:0] rf_read_idx_1, rf_read_idx_2;
   logic [XLEN-1:0]  rf_read_data_1, rf_read_data_2;
   logic [IDX_W-1:0] wb_idx;
   logic [XLEN-1:0]  wb_data;
   logic             wb_enable;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_rs1_val, out_rs2_val;
   logic [TAG_W-1:0] out_tag;
`ifdef OPFETCH_STALL_CNT_EN
   logic [31:0]      stall_cycles;
`endif

   typedef struct packed {
      logic [XLEN-1:0]  v1;
      logic [XLEN-1:0]  v2;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   logic [XLEN-1:0] rf [32];

   always #5 clk = ~clk;

   operand_fetch #(.XLEN(XLEN), .IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_rs1         (in_rs1),
      .in_rs2         (in_rs2),
      .in_tag         (in_tag),
      .rf_read_idx_1  (rf_read_idx_1),
      .rf_read_idx_2  (rf_read_idx_2),
      .rf_read_data_1 (rf_read_data_1),
      .rf_read_data_2 (rf_read_data_2),
      .wb_idx         (wb_idx),
      .wb_data        (wb_data),
      .wb_enable      (wb_enable),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_rs1_val    (out_rs1_val),
      .out_rs2_val    (out_rs2_val),
      .out_tag        (out_tag)
`ifdef OPFETCH_STALL_CNT_EN
      ,
      .stall_cycles   (stall_cycles)
`endif
   );

   // Register file: registered read, write not visible to a same-edge read.
   always @(posedge clk) begin
      rf_read_data_1 <= rf[rf_read_idx_1];
      rf_read_data_2 <= rf[rf_read_idx_2];
      if (wb_enable)
         rf[wb_idx] <= wb_data;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: tag 0x%0h with empty scoreboard", out_tag);
         end else begin
            e = exp_q.pop_front();
            check("out_rs1_val", out_rs1_val, e.v1);
            check("out_rs2_val", out_rs2_val, e.v2);
            check("out_tag", out_tag, e.tag);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_write(input logic [IDX_W-1:0] idx, input logic [XLEN-1:0] data);
      wb_enable = 1'b1;
      wb_idx    = idx;
      wb_data   = data;
      tick();
      wb_enable = 1'b0;
   endtask

   task automatic send(input logic [IDX_W-1:0] r1, input logic [IDX_W-1:0] r2,
                       input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] e1,
                       input logic [XLEN-1:0] e2, input bit expect_out);
      exp_t e;
      int   n;
      in_valid = 1'b1;
      in_rs1   = r1;
      in_rs2   = r2;
      in_tag   = tag;
      if (expect_out) begin
         e.v1  = e1;
         e.v2  = e2;
         e.tag = tag;
         exp_q.push_back(e);
      end
      n = 0;
      #1;
      while (!in_ready && n < 50) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout: tag 0x%0h not accepted within 50 cycles", tag);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      int n;
      for (int i = 0; i < 32; i++) rf[i] = '0;
      reset = 1'b1; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;
      wb_idx = '0; wb_data = '0; wb_enable = 1'b0; out_ready = 1'b1;
      tick(); tick();
      check("reset_out_valid", 32'(out_valid), 32'd0);
      reset = 1'b0;
      tick();
      check("post_reset_in_ready", 32'(in_ready), 32'd1);
      check("post_reset_out_valid", 32'(out_valid), 32'd0);

      wb_write(5, 32'h11);
      wb_write(7, 32'h7777);
      wb_write(3, 32'h3333);
      wb_write(10, 32'hA);
      wb_write(11, 32'hB);
      wb_write(12, 32'hC);
      wb_write(13, 32'hD);

      // Basic read plus two-cycle latency.
      send(5, 0, 32'hA0, 32'h11, 32'h0, 1'b1);
      check("latency_edge1", 32'(out_valid), 32'd0);
      tick();
      check("latency_edge2", 32'(out_valid), 32'd1);
      tick();

      // Write at the accept edge must win over the stale file read.
      wb_enable = 1'b1; wb_idx = 7; wb_data = 32'hBEEF;
      send(7, 5, 32'hB0, 32'hBEEF, 32'h11, 1'b1);
      wb_enable = 1'b0;
      tick(); tick();
      send(7, 7, 32'hB1, 32'hBEEF, 32'hBEEF, 1'b1);
      tick(); tick();

      // Write-back snooped into a held output entry.
      out_ready = 1'b0;
      send(5, 3, 32'hC3, 32'h11, 32'h1234, 1'b1);
      tick();
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_rs2_before_wb", out_rs2_val, 32'h3333);
      wb_write(3, 32'h1234);
      check("hold_rs2_after_wb", out_rs2_val, 32'h1234);
      check("hold_rs1_unchanged", out_rs1_val, 32'h11);
      out_ready = 1'b1;
      tick(); tick();

      // Back-to-back requests with a toggling consumer.
      fork
         begin
            for (int i = 0; i < 12; i++) begin
               out_ready = (i % 2 == 0);
               tick();
            end
            out_ready = 1'b1;
         end
         begin
            send(10, 13, 32'hD0, 32'hA, 32'hD, 1'b1);
            send(11, 12, 32'hD1, 32'hB, 32'hC, 1'b1);
            send(12, 11, 32'hD2, 32'hC, 32'hB, 1'b1);
            send(13, 10, 32'hD3, 32'hD, 32'hA, 1'b1);
         end
      join
      repeat (4) tick();

      // Index 0 reads as zero even after the file holds a nonzero x0.
      wb_write(0, 32'hFFFF);
      wb_enable = 1'b1; wb_idx = 0; wb_data = 32'hFFFF;
      send(0, 5, 32'hE0, 32'h0, 32'h11, 1'b1);
      wb_enable = 1'b0;
      tick(); tick();

      // Reset with both stages occupied discards everything.
      out_ready = 1'b0;
      send(1, 2, 32'h66, 32'h0, 32'h0, 1'b0);
      send(3, 4, 32'h77, 32'h0, 32'h0, 1'b0);
      tick();
      check("full_out_valid", 32'(out_valid), 32'd1);
      check("full_in_ready", 32'(in_ready), 32'd0);
      reset = 1'b1;
      tick();
      check("flush_out_valid", 32'(out_valid), 32'd0);
      reset = 1'b0;
      #1;
      check("flush_in_ready", 32'(in_ready), 32'd1);
`ifdef OPFETCH_STALL_CNT_EN
      check("stall_after_reset", stall_cycles, 32'd0);
`endif
      send(11, 12, 32'h55, 32'hB, 32'hC, 1'b1);
      tick();
      repeat (5) tick();
`ifdef OPFETCH_STALL_CNT_EN
      check("stall_cycles_5", stall_cycles, 32'd5);
`endif
      out_ready = 1'b1;
      tick(); tick();

      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
